b20_enum_ctrl: RTL and testbench
================================

B20_ENUM_CTRL -- requirements
Module: b20_enum_ctrl

Interface
REQ-001 The block SHALL have parameter JOB_DEPTH, default 4, meaning the job queue depth (power of two, 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 15, meaning the candidate counter width (2^CNT_W candidates per job).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and RESETn.
REQ-004 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port RESETn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port JOB_VALID, input, 1 bit: a job is offered.
REQ-007 Port JOB_READY, output, 1 bit: the queue accepts a job.
REQ-008 Port JOB_IDX, input, 4 bits: filter-function index of the job.
REQ-009 Port JOB_BIT, input, 1 bit: required output bit of the job.
REQ-010 Port ABORT, input, 1 bit: flush the queue and cancel the current job.
REQ-011 Port ENUM_IDX, output, 4 bits: selects the enumerator index.
REQ-012 Port ENUM_BIT, output, 1 bit: enumerator target bit.
REQ-013 Port ENUM_CLRn, output, 1 bit: active-low synchronous clear to the enumerator.
REQ-014 Port ENUM_STB, output, 1 bit: advance-enumerator strobe.
REQ-015 Port ENUM_KEY20, input, 20 bits: current enumerator candidate, combinational from enumerator state.
REQ-016 Port CAND_VALID, output, 1 bit: candidate valid.
REQ-017 Port CAND_READY, input, 1 bit: downstream accepts the candidate.
REQ-018 Port CAND_KEY20, output, 20 bits: candidate, equal to ENUM_KEY20.
REQ-019 Port CAND_IDX, output, 4 bits: index tag of the candidate.
REQ-020 Port CAND_LAST, output, 1 bit: final candidate of the job.
REQ-021 Port BUSY, output, 1 bit: asserted when state is not IDLE or the queue is non-empty.
REQ-022 Port JOBS_DONE, output, 16 bits: count of completed jobs, wrapping.

Function
REQ-023 The job queue SHALL be a FIFO of {idx,bit} entries; a push occurs when JOB_VALID & JOB_READY, and JOB_READY=0 whenever the queue is full, including on a simultaneous pop.
REQ-024 The FSM SHALL use states IDLE, LOAD and RUN.
REQ-025 From IDLE, a non-empty queue SHALL cause a transition to LOAD on the next cycle.
REQ-026 In LOAD, which lasts exactly 1 cycle, the block SHALL pop the queue head, latch idx/bit into ENUM_IDX/ENUM_BIT/CAND_IDX, drive ENUM_CLRn=0, and then enter RUN.
REQ-027 In RUN, CAND_VALID SHALL be 1, and ENUM_IDX and ENUM_BIT SHALL be stable.
REQ-028 A handshake SHALL be defined as CAND_VALID & CAND_READY.
REQ-029 Each handshake SHALL increment the CNT_W-bit counter, which is cleared in LOAD.
REQ-030 ENUM_STB SHALL equal handshake & ~CAND_LAST, with zero latency.
REQ-031 CAND_LAST SHALL equal RUN & (counter == 2^CNT_W-1).
REQ-032 A handshake with CAND_LAST=1 SHALL increment JOBS_DONE (wrapping 0xFFFF->0) and move the FSM to LOAD if the queue is non-empty that cycle, else to IDLE; there SHALL be no idle bubble between back-to-back jobs beyond the LOAD cycle.
REQ-033 While CAND_READY=0 in RUN, CAND_VALID, CAND_KEY20 and the counter SHALL hold and ENUM_STB SHALL be 0.
REQ-034 Each job SHALL deliver exactly 2^CNT_W handshakes.
REQ-035 ABORT=1 in any state SHALL empty the queue, move the FSM to IDLE on the next edge and drive ENUM_STB=0 that cycle; CAND_VALID SHALL be 0 from the next cycle, and JOBS_DONE SHALL NOT increment.
REQ-036 A push simultaneous with ABORT SHALL be discarded; JOB_READY SHALL be 0 while ABORT=1.
REQ-037 ENUM_CLRn SHALL be 1 in all states other than LOAD.
REQ-038 CAND_KEY20 SHALL be don't-care when CAND_VALID=0 but SHALL NOT be X-gated.

Reset
REQ-039 RESETn low SHALL asynchronously force: FSM to IDLE, queue empty, counter 0, JOBS_DONE 0, ENUM_IDX 0, ENUM_BIT 0, CAND_IDX 0, CAND_VALID 0, CAND_LAST 0, ENUM_STB 0, ENUM_CLRn 0, BUSY 0, JOB_READY 0.
REQ-040 On the first edge after RESETn deasserts, JOB_READY SHALL be 1 and ENUM_CLRn SHALL be 1.
REQ-041 Reset mid-job SHALL discard the job without a CAND_LAST and without incrementing JOBS_DONE.

Structure
REQ-042 A shared package b20_pkg SHALL hold the FSM state enum, the job struct {idx[3:0], bit}, and constants CAND_PER_JOB = 2**15 and KEY_W = 20.
REQ-043 The job queue SHALL be one sub-module, b20_job_fifo: parameterised depth, registered full/empty, synchronous flush input.
REQ-044 The enumerator SHALL NOT be instantiated inside the block; it connects at the parent level.

Verification
REQ-045 Verification SHALL cover single job: push idx=5, bit=1, with CAND_READY=1 held -> LOAD 1 cycle, 32768 handshakes, CAND_LAST on the 32768th, JOBS_DONE=1, BUSY=0 two cycles later.
REQ-046 Verification SHALL cover backpressure: random 50% CAND_READY -> ENUM_STB count = 32767, no ENUM_STB while CAND_READY=0, and CAND_KEY20 stable across stalls.
REQ-047 Verification SHALL cover queue full: push 5 jobs with no consumption (JOB_DEPTH=4, CNT_W=4) -> JOB_READY=0 after 4 accepted (the first is popped into LOAD, so 5 accepted total); jobs then complete in order idx 0..4 and CAND_IDX tags match.
REQ-048 Verification SHALL cover abort: ABORT at candidate 100 with 2 queued -> CAND_VALID=0 next cycle, BUSY=0, JOBS_DONE unchanged, and a subsequent push with ABORT=1 is ignored.
REQ-049 Verification SHALL cover back-to-back jobs with CNT_W=4: 3 jobs -> exactly 16 handshakes each, exactly one LOAD cycle (ENUM_CLRn=0) between them, JOBS_DONE=3.
REQ-050 Verification SHALL cover async reset mid-RUN: RESETn low between edges -> outputs at reset values immediately; after release, JOB_READY=1 and JOBS_DONE=0.

Source files
------------

// File: rtl/b20_pkg.sv
// Shared types and constants for the enumerator job controller.
package b20_pkg;

   localparam int KEY_W        = 20;
   localparam int CAND_PER_JOB = 2**15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } b20_state_e;

   // "bit" is a reserved word, so the target bit field is req_bit
   typedef struct packed {
      logic [3:0] idx;
      logic       req_bit;
   } b20_job_t;

endpackage

// File: rtl/b20_job_fifo.sv
// Job queue: power-of-two depth, registered full/empty flags, synchronous flush.
module b20_job_fifo
   import b20_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     CLK,
   input  logic     RESETn,
   input  logic     flush,
   input  logic     push,
   input  logic     pop,
   input  b20_job_t wr_data,
   output b20_job_t rd_data,
   output logic     full,
   output logic     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   b20_job_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push & ~do_pop)
         count_nxt = count + 1'b1;
      else if (do_pop & ~do_push)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == FULL_CNT);
         empty <= (count_nxt == '0);
      end
   end

   // Storage carries no reset; the head is only consumed when the queue is non-empty.
   always_ff @(posedge CLK) begin
      if (do_push)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/b20_enum_ctrl.sv
// Sequences queued {idx,bit} jobs through an external enumerator, streaming
// 2^CNT_W candidates per job to a valid/ready consumer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no job active; leave when the queue holds a job
//   ST_LOAD | one cycle: pop head, latch idx/bit, clear enumerator/counter
//   ST_RUN  | candidate valid; advance enumerator on every handshake
module b20_enum_ctrl
   import b20_pkg::*;
#(
   parameter int JOB_DEPTH = 4,
   parameter int CNT_W     = 15
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             JOB_VALID,
   output logic             JOB_READY,
   input  logic [3:0]       JOB_IDX,
   input  logic             JOB_BIT,
   input  logic             ABORT,
   output logic [3:0]       ENUM_IDX,
   output logic             ENUM_BIT,
   output logic             ENUM_CLRn,
   output logic             ENUM_STB,
   input  logic [KEY_W-1:0] ENUM_KEY20,
   output logic             CAND_VALID,
   input  logic             CAND_READY,
   output logic [KEY_W-1:0] CAND_KEY20,
   output logic [3:0]       CAND_IDX,
   output logic             CAND_LAST,
   output logic             BUSY,
   output logic [15:0]      JOBS_DONE
);

   localparam logic [CNT_W-1:0] CNT_LAST = '1;

   b20_state_e       state_q;
   b20_state_e       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [15:0]      jobs_done_q;
   b20_job_t         job_q;
   b20_job_t         job_in;
   b20_job_t         fifo_head;
   logic             live_q;
   logic             fifo_full;
   logic             fifo_empty;
   logic             in_idle;
   logic             in_load;
   logic             in_run;
   logic             hs;
   logic             hs_eff;
   logic             job_done;
   logic             push;
   logic             pop;

   assign in_idle = (state_q == ST_IDLE);
   assign in_load = (state_q == ST_LOAD);
   assign in_run  = (state_q == ST_RUN);

   // ABORT wins over any handshake in the same cycle: nothing advances or completes.
   assign hs       = CAND_VALID & CAND_READY;
   assign hs_eff   = hs & ~ABORT;
   assign job_done = hs_eff & CAND_LAST;

   assign push = JOB_VALID & JOB_READY;
   assign pop  = in_load & ~ABORT;

   assign job_in.idx     = JOB_IDX;
   assign job_in.req_bit = JOB_BIT;

   // live_q holds JOB_READY and ENUM_CLRn low until the first edge after reset release.
   assign JOB_READY  = live_q & ~fifo_full & ~ABORT;
   assign ENUM_CLRn  = live_q & ~in_load;
   assign ENUM_STB   = hs_eff & ~CAND_LAST;
   assign ENUM_IDX   = job_q.idx;
   assign ENUM_BIT   = job_q.req_bit;
   assign CAND_IDX   = job_q.idx;
   assign CAND_VALID = in_run;
   assign CAND_LAST  = in_run & (cnt_q == CNT_LAST);
   assign CAND_KEY20 = ENUM_KEY20;
   assign BUSY       = ~in_idle | ~fifo_empty;
   assign JOBS_DONE  = jobs_done_q;

   b20_job_fifo #(
      .DEPTH (JOB_DEPTH)
   ) u_job_fifo (
      .CLK     (CLK),
      .RESETn  (RESETn),
      .flush   (ABORT),
      .push    (push),
      .pop     (pop),
      .wr_data (job_in),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      if (ABORT) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (job_done) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         jobs_done_q <= '0;
         job_q       <= '0;
         live_q      <= 1'b0;
      end else begin
         live_q  <= 1'b1;
         state_q <= state_d;
         if (pop) begin
            job_q <= fifo_head;
            cnt_q <= '0;
         end else if (hs_eff) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (job_done)
            jobs_done_q <= jobs_done_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_b20_enum_ctrl.sv
// Bench for b20_enum_ctrl: three instances (two full-size, one CNT_W=4) checked
// every cycle against a queue-based model, plus scenario-level literal checks.
module tb_b20_enum_ctrl;
   import b20_pkg::*;

   localparam int NI      = 3;
   localparam int DEPTH   = 4;
   localparam int SMALL_W = 4;
   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_RUN   = 2;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst_n      [NI];
   logic        job_valid  [NI];
   logic        job_ready  [NI];
   logic [3:0]  job_idx    [NI];
   logic        job_bit    [NI];
   logic        abort      [NI];
   logic [3:0]  enum_idx   [NI];
   logic        enum_bit   [NI];
   logic        enum_clrn  [NI];
   logic        enum_stb   [NI];
   logic [19:0] enum_key   [NI];
   logic        cand_valid [NI];
   logic        cand_ready [NI];
   logic [19:0] cand_key   [NI];
   logic [3:0]  cand_idx   [NI];
   logic        cand_last  [NI];
   logic        busy       [NI];
   logic [15:0] jobs_done  [NI];
   logic [14:0] ecnt       [NI];

   int n_cmp = 0;
   int n_err = 0;

   for (genvar g = 0; g < NI; g++) begin : g_inst
      b20_enum_ctrl #(
         .JOB_DEPTH (DEPTH),
         .CNT_W     ((g == 2) ? SMALL_W : 15)
      ) dut (
         .CLK        (CLK),
         .RESETn     (rst_n[g]),
         .JOB_VALID  (job_valid[g]),
         .JOB_READY  (job_ready[g]),
         .JOB_IDX    (job_idx[g]),
         .JOB_BIT    (job_bit[g]),
         .ABORT      (abort[g]),
         .ENUM_IDX   (enum_idx[g]),
         .ENUM_BIT   (enum_bit[g]),
         .ENUM_CLRn  (enum_clrn[g]),
         .ENUM_STB   (enum_stb[g]),
         .ENUM_KEY20 (enum_key[g]),
         .CAND_VALID (cand_valid[g]),
         .CAND_READY (cand_ready[g]),
         .CAND_KEY20 (cand_key[g]),
         .CAND_IDX   (cand_idx[g]),
         .CAND_LAST  (cand_last[g]),
         .BUSY       (busy[g]),
         .JOBS_DONE  (jobs_done[g])
      );

      // Stand-in enumerator: key = {idx, bit, candidate number}.
      initial ecnt[g] = '0;
      always_ff @(posedge CLK) begin
         if (!enum_clrn[g])
            ecnt[g] <= '0;
         else if (enum_stb[g])
            ecnt[g] <= ecnt[g] + 15'd1;
      end
      assign enum_key[g] = {enum_idx[g], enum_bit[g], ecnt[g]};
   end

   // ---------------- behavioural model ----------------
   int         m_mode [NI];
   int         m_cnt  [NI];
   int         m_done [NI];
   logic [4:0] m_cur  [NI];
   bit         m_live [NI];
   logic [4:0] m_q    [NI][DEPTH];
   int         m_qn   [NI];

   function automatic int n_of(input int k);
      return (k == 2) ? (1 << SMALL_W) : CAND_PER_JOB;
   endfunction

   function automatic bit m_ready(input int k);
      return m_live[k] && (m_qn[k] < DEPTH) && !abort[k];
   endfunction

   task automatic m_reset(input int k);
      m_mode[k] = M_IDLE;
      m_cnt[k]  = 0;
      m_done[k] = 0;
      m_cur[k]  = '0;
      m_live[k] = 1'b0;
      m_qn[k]   = 0;
   endtask

   task automatic m_step(input int k);
      bit run, last, hs, push;
      int n_before;
      run      = (m_mode[k] == M_RUN);
      last     = run && (m_cnt[k] == n_of(k) - 1);
      hs       = run && cand_ready[k] && !abort[k];
      push     = job_valid[k] && m_ready(k);
      n_before = m_qn[k];
      if (abort[k]) begin
         m_qn[k]   = 0;
         m_mode[k] = M_IDLE;
      end else begin
         case (m_mode[k])
            M_IDLE: if (m_qn[k] > 0) m_mode[k] = M_LOAD;
            M_LOAD: begin
               m_cur[k] = m_q[k][0];
               for (int i = 0; i < DEPTH - 1; i++) m_q[k][i] = m_q[k][i+1];
               m_qn[k]   = m_qn[k] - 1;
               m_cnt[k]  = 0;
               m_mode[k] = M_RUN;
            end
            default: if (hs) begin
               if (last) begin
                  m_done[k] = (m_done[k] + 1) % 65536;
                  m_mode[k] = (n_before > 0) ? M_LOAD : M_IDLE;
               end else begin
                  m_cnt[k] = m_cnt[k] + 1;
               end
            end
         endcase
         if (push) begin
            m_q[k][m_qn[k]] = {job_idx[k], job_bit[k]};
            m_qn[k] = m_qn[k] + 1;
         end
      end
      m_live[k] = 1'b1;
   endtask

   // Single compare process: check all instances at negedge, advance model at posedge.
   initial begin
      logic [50:0] act, exp;
      bit          run, last;
      logic [19:0] key;
      forever begin
         @(negedge CLK);
         for (int k = 0; k < NI; k++) begin
            if (!rst_n[k]) m_reset(k);
            run  = (m_mode[k] == M_RUN);
            last = run && (m_cnt[k] == n_of(k) - 1);
            key  = run ? {m_cur[k], 15'(m_cnt[k])} : enum_key[k];
            exp  = {m_ready(k), run, last, run && cand_ready[k] && !abort[k] && !last,
                    m_live[k] && (m_mode[k] != M_LOAD), (m_mode[k] != M_IDLE) || (m_qn[k] > 0),
                    16'(m_done[k]), m_cur[k][4:1], m_cur[k][0], m_cur[k][4:1], key};
            act  = {job_ready[k], cand_valid[k], cand_last[k], enum_stb[k], enum_clrn[k], busy[k],
                    jobs_done[k], enum_idx[k], enum_bit[k], cand_idx[k], cand_key[k]};
            n_cmp++;
            if (act !== exp) begin
               n_err++;
               $display("FAIL model_cmp inst%0d t=%0t: got %h expected %h", k, $time, act, exp);
            end
         end
         @(posedge CLK);
         for (int k = 0; k < NI; k++) begin
            if (!rst_n[k]) m_reset(k);
            else m_step(k);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_job(input int k, input int idx, input bit b);
      job_valid[k] = 1'b1;
      job_idx[k]   = idx[3:0];
      job_bit[k]   = b;
      tick();
      job_valid[k] = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic scen_single();
      int hs = 0, loads = 0, last_at = 0, bad_idx = 0;
      cand_ready[0] = 1'b1;
      push_job(0, 5, 1'b1);
      for (int c = 0; c < 40000 && last_at == 0; c++) begin
         @(negedge CLK);
         if (!enum_clrn[0]) loads++;
         if (cand_valid[0] && cand_ready[0]) begin
            hs++;
            if (cand_idx[0] != 4'd5 || enum_bit[0] != 1'b1) bad_idx++;
            if (cand_last[0]) last_at = hs;
         end
      end
      chk("single_handshakes", hs, 32768);
      chk("single_last_position", last_at, 32768);
      chk("single_load_cycles", loads, 1);
      chk("single_idx_tag", bad_idx, 0);
      tick();
      chk("single_jobs_done", jobs_done[0], 1);
      chk("single_model_done", m_done[0], 1);
      tick();
      chk("single_busy_after", busy[0], 0);
   endtask

   task automatic scen_backpressure();
      int stb = 0, bad_stb = 0, key_moves = 0;
      bit stalled = 1'b0, done_seen = 1'b0;
      logic [19:0] prev_key = '0;
      cand_ready[1] = 1'b0;
      push_job(1, 9, 1'b0);
      for (int c = 0; c < 90000 && !done_seen; c++) begin
         cand_ready[1] = ($urandom_range(0, 1) == 1);
         @(negedge CLK);
         if (stalled && cand_valid[1] && cand_key[1] != prev_key) key_moves++;
         stalled  = cand_valid[1] && !cand_ready[1];
         prev_key = cand_key[1];
         if (enum_stb[1]) begin
            stb++;
            if (!cand_ready[1]) bad_stb++;
         end
         if (cand_valid[1] && cand_ready[1] && cand_last[1]) done_seen = 1'b1;
         @(posedge CLK);
         #1;
      end
      chk("bp_job_completed", done_seen, 1);
      chk("bp_strobe_count", stb, 32767);
      chk("bp_strobe_while_stalled", bad_stb, 0);
      chk("bp_key_moved_in_stall", key_moves, 0);
      chk("bp_jobs_done", jobs_done[1], 1);
   endtask

   task automatic rst_small();
      rst_n[2] = 1'b0;
      tick();
      tick();
      rst_n[2] = 1'b1;
      tick();
   endtask

   task automatic scen_small();
      int acc = 0, nlast = 0, order_bad = 0, hs = 0, per_bad = 0, clr = 0, gap = 0;
      bit seen_valid = 1'b0;
      // queue full, then drain in order
      cand_ready[2] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         job_valid[2] = 1'b1;
         job_idx[2]   = acc[3:0];
         job_bit[2]   = acc[0];
         @(negedge CLK);
         if (job_ready[2]) acc++;
         tick();
      end
      job_valid[2] = 1'b0;
      chk("full_accepted", acc, 5);
      chk("full_job_ready", job_ready[2], 0);
      cand_ready[2] = 1'b1;
      for (int c = 0; c < 400 && nlast < 5; c++) begin
         @(negedge CLK);
         if (cand_valid[2] && cand_ready[2]) begin
            hs++;
            if (cand_last[2]) begin
               if (cand_idx[2] != nlast[3:0]) order_bad++;
               nlast++;
            end
         end
      end
      chk("full_jobs_finished", nlast, 5);
      chk("full_order", order_bad, 0);
      chk("full_handshakes", hs, 80);
      tick();
      chk("full_jobs_done", jobs_done[2], 5);
      chk("full_model_done", m_done[2], 5);

      // back-to-back
      rst_small();
      push_job(2, 10, 1'b1);
      push_job(2, 11, 1'b0);
      push_job(2, 12, 1'b1);
      hs = 0;
      nlast = 0;
      for (int c = 0; c < 200 && nlast < 3; c++) begin
         @(negedge CLK);
         if (!enum_clrn[2]) clr++;
         if (seen_valid && !cand_valid[2]) gap++;
         if (cand_valid[2]) seen_valid = 1'b1;
         if (cand_valid[2] && cand_ready[2]) begin
            hs++;
            if (cand_last[2]) begin
               if (hs != 16) per_bad++;
               hs = 0;
               nlast++;
            end
         end
      end
      chk("b2b_jobs_finished", nlast, 3);
      chk("b2b_per_job_count", per_bad, 0);
      chk("b2b_load_cycles", clr, 2);
      chk("b2b_gap_cycles", gap, 2);
      tick();
      chk("b2b_jobs_done", jobs_done[2], 3);

      // async reset mid-run
      push_job(2, 7, 1'b1);
      repeat (6) tick();
      chk("rst_in_run", cand_valid[2], 1);
      #2;
      rst_n[2] = 1'b0;
      #1;
      chk("rst_outputs_zero", {cand_valid[2], cand_last[2], enum_stb[2], enum_clrn[2], busy[2],
                               job_ready[2], enum_bit[2], enum_idx[2], cand_idx[2], jobs_done[2]}, 0);
      tick();
      rst_n[2] = 1'b1;
      tick();
      chk("rst_job_ready_after", job_ready[2], 1);
      chk("rst_clrn_after", enum_clrn[2], 1);
      chk("rst_jobs_done_after", jobs_done[2], 0);

      // abort at candidate 10 with two jobs queued
      push_job(2, 1, 1'b0);
      push_job(2, 2, 1'b1);
      push_job(2, 3, 1'b0);
      hs = 0;
      for (int c = 0; c < 100 && hs < 10; c++) begin
         @(negedge CLK);
         if (cand_valid[2] && cand_ready[2]) hs++;
      end
      chk("abort_reached_candidate", hs, 10);
      tick();
      abort[2]     = 1'b1;
      job_valid[2] = 1'b1;
      job_idx[2]   = 4'd15;
      @(negedge CLK);
      chk("abort_job_ready", job_ready[2], 0);
      chk("abort_strobe", enum_stb[2], 0);
      tick();
      abort[2]     = 1'b0;
      job_valid[2] = 1'b0;
      chk("abort_cand_valid", cand_valid[2], 0);
      chk("abort_busy", busy[2], 0);
      chk("abort_jobs_done", jobs_done[2], 0);
      repeat (3) tick();
      chk("abort_push_ignored", busy[2], 0);
      push_job(2, 4, 1'b1);
      nlast = 0;
      for (int c = 0; c < 60 && nlast == 0; c++) begin
         @(negedge CLK);
         if (cand_valid[2] && cand_ready[2] && cand_last[2]) nlast++;
      end
      tick();
      chk("post_abort_jobs_done", jobs_done[2], 1);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_n[k]      = 1'b0;
         job_valid[k]  = 1'b0;
         job_idx[k]    = '0;
         job_bit[k]    = 1'b0;
         abort[k]      = 1'b0;
         cand_ready[k] = 1'b0;
      end
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_job_ready", job_ready[0], 0);
      chk("reset_enum_clrn", enum_clrn[0], 0);
      chk("reset_busy", busy[0], 0);
      for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
      tick();
      chk("release_job_ready", job_ready[0], 1);
      chk("release_enum_clrn", enum_clrn[0], 1);
      fork
         scen_single();
         scen_backpressure();
         scen_small();
      join
      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
